// File: rtl/corefifo_vdma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : corefifo_vdma_pkg
// Description : Shared constants and the width-masked gray-to-binary decoder
//               used by the VDMA FIFO pointer synchronisers.
// Revision    : 1.0 - initial release
// ============================================================================
package corefifo_vdma_pkg;

  localparam int MIN_STAGES = 2;
  localparam int MAX_STAGES = 8;
  localparam int MAX_CH     = 8;
  localparam int MAX_PTR_W  = 16;

  // Decode a gray value of 'width' bits held in the low end of a 16-bit word.
  // Bits above 'width' are masked off on the way in and on the way out, so
  // one function body serves every pointer width up to 16.
  function automatic logic [15:0] gray2bin(input logic [15:0] gray,
                                           input int unsigned width);
    logic [15:0] mask;
    logic [15:0] g;
    logic [15:0] b;
    mask  = (width >= 16) ? 16'hFFFF : 16'((32'd1 << width) - 32'd1);
    g     = gray & mask;
    b     = '0;
    b[15] = g[15];
    for (int k = 14; k >= 0; k--) begin
      b[k] = b[k+1] ^ g[k];
    end
    return b & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/corefifo_ptr_sync_vdma_if.sv
`default_nettype none
// ============================================================================
// Module      : corefifo_ptr_sync_vdma_if
// Description : Pointer bus of the multi-channel synchroniser: packed gray
//               inputs, synchronised gray, decoded binary and change strobes.
// Revision    : 1.0 - initial release
// ============================================================================
interface corefifo_ptr_sync_vdma_if #(
  parameter int NUM_CH = 1,
  parameter int PTR_W  = 4
);

  logic [NUM_CH*PTR_W-1:0] inp;
  logic [NUM_CH*PTR_W-1:0] sync_out;
  logic [NUM_CH*PTR_W-1:0] bin_out;
  logic [NUM_CH-1:0]       chg;

  // Side that produces pointers and consumes the synchronised results
  modport master (output inp, input sync_out, input bin_out, input chg);

  // The synchroniser itself
  modport slave  (input inp, output sync_out, output bin_out, output chg);

endinterface
`default_nettype wire

// File: rtl/corefifo_ptr_sync_ch_vdma.sv
`default_nettype none
// ============================================================================
// Module      : corefifo_ptr_sync_ch_vdma
// Description : One channel of the pointer synchroniser: register chain,
//               optional stability filter, registered gray decode and a
//               change strobe that rises together with the new binary value.
// Revision    : 1.0 - initial release
// ============================================================================
module corefifo_ptr_sync_ch_vdma
  import corefifo_vdma_pkg::*;
#(
  parameter int NUM_STAGES = 2,
  parameter int PTR_W      = 4,
  parameter int FILTER     = 0
) (
  input  wire logic             clk,
  input  wire logic             rstn,
  input  wire logic             sclr,
  input  wire logic [PTR_W-1:0] inp,
  output logic      [PTR_W-1:0] sync_out,
  output logic      [PTR_W-1:0] bin_out,
  output logic                  chg
);

  // r_chain[0] is the capture stage, r_chain[NUM_STAGES-1] the oldest value
  logic [NUM_STAGES-1:0][PTR_W-1:0] r_chain;
  logic [PTR_W-1:0]                 w_sync;
  logic [PTR_W-1:0]                 w_bin;
  logic [PTR_W-1:0]                 r_bin;
  logic                             r_chg;

  // Capture the incoming gray pointer and shift it down the chain
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_chain <= '0;
    end else if (sclr) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[NUM_STAGES-2:0], inp};
    end
  end

  generate
    if (FILTER != 0) begin : g_filter
      logic [PTR_W-1:0] r_hold;

      // Accept the chain output only once the last two stages agree, so a
      // pointer caught mid-transition never reaches the decoder
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_hold <= '0;
        end else if (sclr) begin
          r_hold <= '0;
        end else if (r_chain[NUM_STAGES-1] == r_chain[NUM_STAGES-2]) begin
          r_hold <= r_chain[NUM_STAGES-1];
        end
      end

      assign w_sync = r_hold;
    end else begin : g_nofilter
      // Last chain stage drives the output directly to keep legacy latency
      assign w_sync = r_chain[NUM_STAGES-1];
    end
  endgenerate

  assign w_bin = PTR_W'(gray2bin(16'(w_sync), PTR_W));

  // Register the decode and flag a change whenever the decode moves
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_bin <= '0;
      r_chg <= 1'b0;
    end else if (sclr) begin
      r_bin <= '0;
      r_chg <= 1'b0;
    end else begin
      r_bin <= w_bin;
      r_chg <= (w_bin != r_bin);
    end
  end

  assign sync_out = w_sync;
  assign bin_out  = r_bin;
  assign chg      = r_chg;

endmodule
`default_nettype wire

// File: rtl/corefifo_ptr_sync_vdma.sv
`default_nettype none
// ============================================================================
// Module      : corefifo_ptr_sync_vdma
// Description : Multi-channel gray pointer synchroniser for the VDMA FIFOs.
//               Replicates the single-channel synchroniser NUM_CH times and
//               packs/unpacks the shared pointer buses.
// Revision    : 1.0 - initial release
// ============================================================================
module corefifo_ptr_sync_vdma
  import corefifo_vdma_pkg::*;
#(
  parameter int NUM_STAGES = 2,
  parameter int ADDRWIDTH  = 3,
  parameter int NUM_CH     = 1,
  parameter int FILTER     = 0
) (
  input  wire logic                 clk,
  input  wire logic                 rstn,
  input  wire logic                 sclr,
  corefifo_ptr_sync_vdma_if.slave   bus
);

  localparam int PTR_W = ADDRWIDTH + 1;

  // Reject configurations the channel logic was not built for
  generate
    if (NUM_STAGES < MIN_STAGES || NUM_STAGES > MAX_STAGES) begin : g_bad_stages
      $error("corefifo_ptr_sync_vdma: NUM_STAGES out of range 2..8");
    end
    if (ADDRWIDTH < 0 || PTR_W > MAX_PTR_W) begin : g_bad_addrwidth
      $error("corefifo_ptr_sync_vdma: ADDRWIDTH out of range 0..15");
    end
    if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_ch
      $error("corefifo_ptr_sync_vdma: NUM_CH out of range 1..8");
    end
    if (FILTER != 0 && FILTER != 1) begin : g_bad_filter
      $error("corefifo_ptr_sync_vdma: FILTER must be 0 or 1");
    end
  endgenerate

  logic [NUM_CH*PTR_W-1:0] w_inp;
  logic [NUM_CH*PTR_W-1:0] w_sync;
  logic [NUM_CH*PTR_W-1:0] w_bin;
  logic [NUM_CH-1:0]       w_chg;

  assign w_inp = bus.inp;

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      corefifo_ptr_sync_ch_vdma #(
        .NUM_STAGES (NUM_STAGES),
        .PTR_W      (PTR_W),
        .FILTER     (FILTER)
      ) u_ch (
        .clk      (clk),
        .rstn     (rstn),
        .sclr     (sclr),
        .inp      (w_inp[c*PTR_W +: PTR_W]),
        .sync_out (w_sync[c*PTR_W +: PTR_W]),
        .bin_out  (w_bin[c*PTR_W +: PTR_W]),
        .chg      (w_chg[c])
      );
    end
  endgenerate

  assign bus.sync_out = w_sync;
  assign bus.bin_out  = w_bin;
  assign bus.chg      = w_chg;

endmodule
`default_nettype wire

// File: tb/tb_corefifo_ptr_sync_vdma.sv
`default_nettype none
// ============================================================================
// Module      : tb_corefifo_ptr_sync_vdma
// Description : Scoreboard bench for the pointer synchroniser. Three DUTs
//               (different depth / filter settings, 4 channels, 4-bit
//               pointers) share one stimulus stream; a history-based
//               reference model predicts every cycle's outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_corefifo_ptr_sync_vdma;

  localparam int NCH = 4;
  localparam int AW  = 3;
  localparam int W   = AW + 1;
  localparam int WT  = NCH * W;
  localparam int ND  = 3;

  function automatic int ns_of(input int d);
    case (d)
      0:       return 3;
      1:       return 2;
      default: return 5;
    endcase
  endfunction

  function automatic int fi_of(input int d);
    return (d == 1) ? 1 : 0;
  endfunction

  logic          clk  = 1'b0;
  logic          rstn = 1'b0;
  logic          sclr = 1'b0;
  logic [WT-1:0] inp  = '1;

  logic [WT-1:0]  sync_o [ND];
  logic [WT-1:0]  bin_o  [ND];
  logic [NCH-1:0] chg_o  [ND];

  always #5 clk = ~clk;

  for (genvar d = 0; d < ND; d++) begin : g_dut
    corefifo_ptr_sync_vdma_if #(.NUM_CH(NCH), .PTR_W(W)) bus ();

    assign bus.inp   = inp;
    assign sync_o[d] = bus.sync_out;
    assign bin_o[d]  = bus.bin_out;
    assign chg_o[d]  = bus.chg;

    corefifo_ptr_sync_vdma #(
      .NUM_STAGES (ns_of(d)),
      .ADDRWIDTH  (AW),
      .NUM_CH     (NCH),
      .FILTER     (fi_of(d))
    ) u_dut (
      .clk  (clk),
      .rstn (rstn),
      .sclr (sclr),
      .bus  (bus)
    );
  end

  // ---------------- reference model ----------------
  logic [WT-1:0] hist[$];                 // samples taken since last clear
  logic [ND-1:0][WT-1:0]  m_sync, m_bin;
  logic [ND-1:0][NCH-1:0] m_chg;

  logic [ND-1:0][WT-1:0]  exp_sync_q[$];
  logic [ND-1:0][WT-1:0]  exp_bin_q[$];
  logic [ND-1:0][NCH-1:0] exp_chg_q[$];

  // Binary bit k of a gray code is the parity of all gray bits at or above k
  function automatic logic [W-1:0] ref_g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    for (int k = 0; k < W; k++) b[k] = ^(g >> k);
    return b;
  endfunction

  // Value sampled at edge x since the last clear (zero before any sample)
  function automatic logic [WT-1:0] samp(input int x);
    if (x <= 0) return '0;
    return hist[x-1];
  endfunction

  task automatic model_reset();
    hist.delete();
    m_sync = '0;
    m_bin  = '0;
    m_chg  = '0;
  endtask

  task automatic model_edge(input logic [WT-1:0] i, input logic s, input logic r);
    int t;
    int n;
    logic [WT-1:0] a;
    logic [WT-1:0] b;
    logic [W-1:0]  nb;
    if (!r || s) begin
      model_reset();
    end else begin
      hist.push_back(i);
      t = hist.size();
      for (int d = 0; d < ND; d++) begin
        n = ns_of(d);
        a = samp(t - n);
        b = samp(t - n + 1);
        for (int c = 0; c < NCH; c++) begin
          nb = ref_g2b(m_sync[d][c*W +: W]);
          m_chg[d][c] = (nb != m_bin[d][c*W +: W]);
          m_bin[d][c*W +: W] = nb;
          if (fi_of(d) == 0)
            m_sync[d][c*W +: W] = b[c*W +: W];
          else if (a[c*W +: W] == b[c*W +: W])
            m_sync[d][c*W +: W] = a[c*W +: W];
        end
      end
    end
  endtask

  task automatic push_exp();
    exp_sync_q.push_back(m_sync);
    exp_bin_q.push_back(m_bin);
    exp_chg_q.push_back(m_chg);
  endtask

  // ---------------- driver ----------------
  logic done    = 1'b0;
  logic cnt_en  = 1'b0;
  logic cnt_chk = 1'b0;

  task automatic step(input logic [WT-1:0] nxt_inp, input logic nxt_sclr,
                      input logic nxt_rstn, input bit async_rst);
    @(posedge clk);
    model_edge(inp, sclr, rstn);
    #1;
    if (async_rst) begin
      #2;
      rstn = 1'b0;
      model_reset();
    end
    push_exp();
    inp  = nxt_inp;
    sclr = nxt_sclr;
    if (!async_rst) rstn = nxt_rstn;
  endtask

  task automatic run(input int n, input logic [WT-1:0] v);
    for (int k = 0; k < n; k++) step(v, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic clear_then(input logic [WT-1:0] v);
    step(v, 1'b1, 1'b1, 1'b0);
  endtask

  function automatic logic [WT-1:0] all_ch(input logic [W-1:0] g);
    return {NCH{g}};
  endfunction

  int ptr [NCH];

  initial begin
    // reset held with all-ones on the inputs, then released
    step('1, 1'b0, 1'b0, 1'b0);
    step('1, 1'b0, 1'b0, 1'b0);
    step('1, 1'b0, 1'b1, 1'b0);
    run(10, '1);

    // latency step 0 -> 1 on every channel
    clear_then('0);
    run(3, '0);
    run(10, all_ch(4'b0001));

    // gray walk 0..15 and back to 0, three cycles per value
    clear_then('0);
    cnt_en = 1'b1;
    for (int v = 0; v < 16; v++) begin
      logic [W-1:0] bv;
      bv = W'(v);
      run(3, all_ch(bv ^ (bv >> 1)));
    end
    run(10, '0);
    cnt_en  = 1'b0;
    cnt_chk = 1'b1;
    run(1, '0);
    cnt_chk = 1'b0;

    // filter: toggle 0001/0011 every cycle, then hold 0011
    clear_then('0);
    for (int k = 0; k < 20; k++) run(1, all_ch((k % 2 == 0) ? 4'b0001 : 4'b0011));
    run(10, all_ch(4'b0011));

    // only channel 2 steps
    clear_then('0);
    run(10, WT'(4'b0001) << (2*W));

    // directed mid-stream clears: sclr, then async reset between edges
    clear_then('0);
    run(4, all_ch(4'b0001));
    run(2, all_ch(4'b0011));
    step(all_ch(4'b0010), 1'b1, 1'b1, 1'b0);
    run(4, all_ch(4'b0110));
    step(all_ch(4'b0111), 1'b0, 1'b1, 1'b1);
    run(10, all_ch(4'b0101));

    // randomized pointer traffic with occasional glitches and clears
    for (int c = 0; c < NCH; c++) ptr[c] = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      logic [WT-1:0] nv;
      logic [W-1:0]  bp;
      int r;
      for (int c = 0; c < NCH; c++) begin
        r = $urandom_range(0, 9);
        if (r < 4) ptr[c] = ptr[c] + 1;
        bp = W'(ptr[c]);
        nv[c*W +: W] = (r == 9) ? W'($urandom) : (bp ^ (bp >> 1));
      end
      if ($urandom_range(0, 149) == 0)
        step(nv, 1'b0, 1'b1, 1'b1);
      else
        step(nv, ($urandom_range(0, 79) == 0), 1'b1, 1'b0);
    end
    run(8, '0);
    done = 1'b1;
  end

  // ---------------- monitor / scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  int chg_cnt [ND];

  task automatic check(input string name, input int d,
                       input logic [WT-1:0] act, input logic [WT-1:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s dut%0d @%0t: got %h expected %h", name, d, $time, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    logic [ND-1:0][WT-1:0]  es;
    logic [ND-1:0][WT-1:0]  eb;
    logic [ND-1:0][NCH-1:0] ec;
    if (exp_sync_q.size() > 0) begin
      es = exp_sync_q.pop_front();
      eb = exp_bin_q.pop_front();
      ec = exp_chg_q.pop_front();
      for (int d = 0; d < ND; d++) begin
        check("sync_out", d, sync_o[d], es[d]);
        check("bin_out", d, bin_o[d], eb[d]);
        check("chg", d, WT'(chg_o[d]), WT'(ec[d]));
      end
    end
    if (cnt_en) begin
      for (int d = 0; d < ND; d++) if (chg_o[d][0]) chg_cnt[d]++;
    end
    if (cnt_chk) begin
      for (int d = 0; d < ND; d++) check("wrap_chg_count", d, WT'(chg_cnt[d]), WT'(16));
    end
    if (!cnt_en) begin
      for (int d = 0; d < ND; d++) chg_cnt[d] = 0;
    end
    if (done) begin
      check("queue_drained", 0, WT'(exp_sync_q.size()), '0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not reach its end within the time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
